i2s_frame_scheduler: RTL and testbench
======================================

Name: i2s_frame_scheduler

Overview:
Controller that decides when the I2S video streamer may transmit a frame to the ESP and tracks progress through it. Inputs: camera v_sync, ESP clear-to-send (cts) and a per-pixel strobe from the streamer. Output: the send_frame gate, plus frame decimation, a stall watchdog and status counters. Sits between the video pipeline's sync outputs and the 16-bit I2S streamer, all in the mclk domain.

Parameters:
FRAME_PIXELS, 307200, pixels per complete frame (640x480)
PIX_W, 19, width of pixel counter (must hold FRAME_PIXELS-1)
TIMEOUT, 4096, mclk cycles without pix_stb in SEND before the watchdog fires
WD_W, 12, watchdog counter width (must hold TIMEOUT-1)

Ports:
mclk  in  1  sole clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
v_sync  in  1  camera vertical sync, asynchronous, frame boundary = falling edge
cts  in  1  ESP clear-to-send, asynchronous, level
enable  in  1  mclk-domain master enable
decim  in  4  send every decim-th eligible frame; 0 treated as 1
pix_stb  in  1  one-cycle pulse per pixel shifted out by the streamer
err_clr  in  1  one-cycle pulse, clears timeout error
send_frame  out  1  gate to streamer (bclk/data enable)
frame_start  out  1  one-cycle pulse on entering SEND
frame_done  out  1  one-cycle pulse in DONE
pix_count  out  PIX_W  pixels sent in current frame
frames_sent  out  16  completed frames, wraps
frames_skipped  out  16  boundaries not used to start a frame, saturates at 0xFFFF
timeout_err  out  1  sticky watchdog flag
state  out  2  IDLE=0, SEND=1, DONE=2, ERR=3

Behaviour:
- Reset: all outputs 0, state IDLE, decimation counter 0. v_sync synchronizer flops reset to 1 and cts synchronizer flops reset to 0, so no spurious edge after reset release.
- Synchronizers: v_sync and cts each pass through 2 flops. An extra previous-value flop on v_sync gives vs_fall = prev & ~cur, a single cycle.
- Latency: v_sync falls before edge k. vs_fall is high in the cycle after edge k+2, and send_frame/frame_start are registered at edge k+3.
- IDLE, on vs_fall with enable=1 and cts_s=1:
  - If dec_cnt == max(decim,1)-1: dec_cnt <= 0, go to SEND, pulse frame_start, clear pix_count and watchdog.
  - Else: dec_cnt++, frames_skipped++.
- IDLE, on vs_fall with enable=1 and cts_s=0: frames_skipped++, dec_cnt unchanged.
- IDLE, on vs_fall with enable=0: ignored, no counter changes.
- SEND: send_frame=1.
  - Each pix_stb increments pix_count and clears the watchdog. Otherwise the watchdog increments.
  - pix_stb with pix_count == FRAME_PIXELS-1: go to DONE; pix_count ends at FRAME_PIXELS-1.
  - vs_fall in SEND (short frame): go to DONE. That boundary is consumed; it starts no frame and is not counted as skipped.
  - Simultaneous final pix_stb and vs_fall: single DONE, identical result.
  - cts dropping mid-frame is ignored; cts is sampled only at the frame start.
  - enable=0 in SEND: abort to IDLE at next edge, send_frame low, no frame_done, frames_sent unchanged.
  - Watchdog reaching TIMEOUT-1 without pix_stb: go to ERR and set timeout_err. Priority: enable abort > watchdog > completion.
- DONE: lasts exactly one cycle. frame_done=1, send_frame=0, frames_sent++ (wraps 0xFFFF→0). Then IDLE. pix_count holds until the next frame_start.
- ERR: send_frame=0. All vs_fall are ignored. err_clr returns to IDLE and clears timeout_err; err_clr in other states has no effect.
- Async reset mid-frame: send_frame drops immediately. After release, the first frame needs a fresh vs_fall.
- decim change is taken at each vs_fall evaluation. If dec_cnt ≥ new decim-1, the next eligible boundary sends.

Test Plan:
1. Frame send. FRAME_PIXELS=16, decim=1, cts=1, enable=1, one v_sync fall, then 16 pix_stb → frame_start 3 edges after the fall, pix_count 15, frame_done once, frames_sent=1, state back to 0.
2. Decimation. decim=3, 6 v_sync falls, each frame fully strobed → frames sent on the 3rd and 6th falls, frames_sent=2, frames_skipped=4.
3. cts gating. cts=0 at the 1st fall, 1 at the 2nd; drop cts during the 2nd frame → only the 2nd frame sent and completes, frames_skipped=1.
4. Short frame. v_sync falls again after 10 of 16 pixels → DONE with pix_count=10, frames_sent increments, no new frame_start from that fall.
5. Watchdog. TIMEOUT=32, enter SEND, no pix_stb → ERR after 32 cycles, timeout_err=1, send_frame=0. Next v_sync fall ignored; err_clr → IDLE, flag cleared.
6. Abort and reset. enable→0 mid-frame → IDLE, no frame_done. Separately, assert reset mid-frame → all outputs 0 asynchronously, no frame_start without a new v_sync fall.

Source files
------------

// File: rtl/i2s_frame_scheduler.sv
// Frame-level gate for the I2S video streamer: waits for a camera frame boundary with the ESP
// ready, applies decimation, tracks pixel progress and guards against a stalled streamer.
module i2s_frame_scheduler #(
    parameter int FRAME_PIXELS = 307200,
    parameter int PIX_W        = 19,
    parameter int TIMEOUT      = 4096,
    parameter int WD_W         = 12
) (
    input  logic             i_mclk,
    input  logic             i_reset,
    input  logic             i_v_sync,
    input  logic             i_cts,
    input  logic             i_enable,
    input  logic [3:0]       i_decim,
    input  logic             i_pix_stb,
    input  logic             i_err_clr,
    output logic             o_send_frame,
    output logic             o_frame_start,
    output logic             o_frame_done,
    output logic [PIX_W-1:0] o_pix_count,
    output logic [15:0]      o_frames_sent,
    output logic [15:0]      o_frames_skipped,
    output logic             o_timeout_err,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIXELS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

    logic [1:0]       r_vs_sync;
    logic             r_vs_prev;
    logic             r_vs_fall;
    logic [1:0]       r_cts_sync;

    state_t           r_state;
    logic [3:0]       r_dec_cnt;
    logic [WD_W-1:0]  r_wd;
    logic             r_send_frame;
    logic             r_frame_start;
    logic             r_frame_done;
    logic [PIX_W-1:0] r_pix_count;
    logic [15:0]      r_frames_sent;
    logic [15:0]      r_frames_skipped;
    logic             r_timeout_err;

    logic             w_cts_s;
    logic [3:0]       w_decim_m1;
    logic             w_last_pix;
    logic             w_wd_expired;

    assign w_cts_s      = r_cts_sync[1];
    assign w_decim_m1   = (i_decim == 4'd0) ? 4'd0 : i_decim - 4'd1;
    assign w_last_pix   = (r_pix_count == PIX_LAST);
    assign w_wd_expired = (r_wd == WD_LAST);

    // NOTE: v_sync flops reset high (its idle level) so releasing reset cannot fake a falling edge.
    always_ff @(posedge i_mclk or posedge i_reset) begin
        if (i_reset) begin
            r_vs_sync  <= 2'b11;
            r_vs_prev  <= 1'b1;
            r_vs_fall  <= 1'b0;
            r_cts_sync <= 2'b00;
        end else begin
            r_vs_sync  <= {r_vs_sync[0], i_v_sync};
            r_vs_prev  <= r_vs_sync[1];
            r_vs_fall  <= r_vs_prev & ~r_vs_sync[1];
            r_cts_sync <= {r_cts_sync[0], i_cts};
        end
    end

    always_ff @(posedge i_mclk or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= ST_IDLE;
            r_dec_cnt        <= 4'd0;
            r_wd             <= '0;
            r_send_frame     <= 1'b0;
            r_frame_start    <= 1'b0;
            r_frame_done     <= 1'b0;
            r_pix_count      <= '0;
            r_frames_sent    <= 16'd0;
            r_frames_skipped <= 16'd0;
            r_timeout_err    <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_vs_fall && i_enable) begin
                        if (w_cts_s && (r_dec_cnt >= w_decim_m1)) begin
                            r_dec_cnt     <= 4'd0;
                            r_state       <= ST_SEND;
                            r_send_frame  <= 1'b1;
                            r_frame_start <= 1'b1;
                            r_pix_count   <= '0;
                            r_wd          <= '0;
                        end else begin
                            if (w_cts_s) begin
                                r_dec_cnt <= r_dec_cnt + 4'd1;
                            end
                            if (r_frames_skipped != 16'hFFFF) begin
                                r_frames_skipped <= r_frames_skipped + 16'd1;
                            end
                        end
                    end
                end
                ST_SEND: begin
                    // Abort outranks the watchdog, which outranks normal or short completion.
                    if (!i_enable) begin
                        r_state      <= ST_IDLE;
                        r_send_frame <= 1'b0;
                    end else if (!i_pix_stb && w_wd_expired) begin
                        r_state       <= ST_ERR;
                        r_send_frame  <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        if (i_pix_stb) begin
                            r_wd <= '0;
                            if (!w_last_pix) begin
                                r_pix_count <= r_pix_count + PIX_W'(1);
                            end
                        end else begin
                            r_wd <= r_wd + WD_W'(1);
                        end
                        if ((i_pix_stb && w_last_pix) || r_vs_fall) begin
                            r_state       <= ST_DONE;
                            r_send_frame  <= 1'b0;
                            r_frame_done  <= 1'b1;
                            r_frames_sent <= r_frames_sent + 16'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_ERR: begin
                    if (i_err_clr) begin
                        r_state       <= ST_IDLE;
                        r_timeout_err <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_send_frame     = r_send_frame;
    assign o_frame_start    = r_frame_start;
    assign o_frame_done     = r_frame_done;
    assign o_pix_count      = r_pix_count;
    assign o_frames_sent    = r_frames_sent;
    assign o_frames_skipped = r_frames_skipped;
    assign o_timeout_err    = r_timeout_err;
    assign o_state          = r_state;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Randomized scoreboard bench for i2s_frame_scheduler: a frame-level model queues the expected
// frame_start/frame_done events and a monitor compares them as the DUT pulses.
module tb_i2s_frame_scheduler;

    localparam int FP = 16;
    localparam int PW = 4;
    localparam int TO = 32;
    localparam int WW = 5;

    logic          mclk = 1'b0;
    logic          rst;
    logic          v_sync;
    logic          cts;
    logic          enable;
    logic [3:0]    decim;
    logic          pix_stb;
    logic          err_clr;
    logic          send_frame;
    logic          frame_start;
    logic          frame_done;
    logic [PW-1:0] pix_count;
    logic [15:0]   frames_sent;
    logic [15:0]   frames_skipped;
    logic          timeout_err;
    logic [1:0]    state;

    i2s_frame_scheduler #(
        .FRAME_PIXELS(FP), .PIX_W(PW), .TIMEOUT(TO), .WD_W(WW)
    ) dut (
        .i_mclk          (mclk),
        .i_reset         (rst),
        .i_v_sync        (v_sync),
        .i_cts           (cts),
        .i_enable        (enable),
        .i_decim         (decim),
        .i_pix_stb       (pix_stb),
        .i_err_clr       (err_clr),
        .o_send_frame    (send_frame),
        .o_frame_start   (frame_start),
        .o_frame_done    (frame_done),
        .o_pix_count     (pix_count),
        .o_frames_sent   (frames_sent),
        .o_frames_skipped(frames_skipped),
        .o_timeout_err   (timeout_err),
        .o_state         (state)
    );

    always #5 mclk = ~mclk;

    typedef enum int {EV_START = 0, EV_DONE = 1} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       pix;
        int       sent;
        int       skipped;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  n_start = 0;

    // Frame-level reference: counts of frames and boundaries, nothing cycle-accurate.
    int  m_sent = 0;
    int  m_skip = 0;
    int  m_elig = 0;
    int  m_pix = 0;
    bit  m_in_frame = 0;
    bit  m_err = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input int pix);
        ev_t e;
        e.kind    = k;
        e.pix     = pix;
        e.sent    = m_sent;
        e.skipped = m_skip;
        exp_q.push_back(e);
    endtask

    task automatic model_boundary();
        int eff_decim;
        eff_decim = (decim == 0) ? 1 : int'(decim);
        if (m_err) return;
        if (m_in_frame) begin
            m_in_frame = 0;
            m_sent     = (m_sent + 1) % 65536;
            push_ev(EV_DONE, m_pix);
        end else if (enable) begin
            if (cts && (m_elig + 1 >= eff_decim)) begin
                m_elig     = 0;
                m_in_frame = 1;
                m_pix      = 0;
                push_ev(EV_START, 0);
            end else begin
                if (cts) m_elig++;
                if (m_skip < 65535) m_skip++;
            end
        end
    endtask

    task automatic model_pix();
        if (!m_in_frame) return;
        m_pix++;
        if (m_pix == FP) begin
            m_in_frame = 0;
            m_sent     = (m_sent + 1) % 65536;
            push_ev(EV_DONE, FP - 1);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic vs_pulse();
        model_boundary();
        v_sync = 1'b0;
        tick(5);
        v_sync = 1'b1;
        tick(4);
    endtask

    task automatic strobes(input int n);
        for (int i = 0; i < n; i++) begin
            pix_stb = 1'b1;
            model_pix();
            tick(1);
            pix_stb = 1'b0;
            tick($urandom_range(0, 3));
        end
    endtask

    always @(negedge mclk) begin
        if (!rst && (frame_start || frame_done)) begin
            if (frame_start) n_start++;
            if (exp_q.size() == 0) begin
                check("unexpected_event", {30'd0, frame_done, frame_start}, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_kind", frame_done ? 1 : 0, int'(e.kind));
                check("ev_send_frame", int'(send_frame), (e.kind == EV_START) ? 1 : 0);
                check("ev_pix_count", int'(pix_count), e.pix);
                check("ev_frames_sent", int'(frames_sent), e.sent);
                check("ev_frames_skipped", int'(frames_skipped), e.skipped);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int skip0;
        int sent0;
        int starts0;
        rst = 1'b1; v_sync = 1'b1; cts = 1'b0; enable = 1'b0;
        decim = 4'd1; pix_stb = 1'b0; err_clr = 1'b0;
        tick(3);
        check("rst_send_frame", int'(send_frame), 0);
        check("rst_state", int'(state), 0);
        check("rst_pix_count", int'(pix_count), 0);
        check("rst_frames_sent", int'(frames_sent), 0);
        check("rst_frames_skipped", int'(frames_skipped), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        rst = 1'b0;
        tick(2);
        enable = 1'b1; cts = 1'b1;
        tick(3);
        check("idle_no_spurious_start", n_start, 0);

        // Single full frame, with boundary-to-frame_start latency.
        model_boundary();
        v_sync = 1'b0;
        n = 0;
        while (!frame_start && n < 20) begin
            tick(1);
            n++;
        end
        check("start_latency", n, 4);
        v_sync = 1'b1;
        tick(2);
        strobes(FP);
        tick(3);
        check("t1_pix_count_hold", int'(pix_count), FP - 1);
        check("t1_frames_sent", int'(frames_sent), 1);
        check("t1_state_idle", int'(state), 0);

        // Decimation by 3 over six boundaries.
        decim = 4'd3;
        skip0 = m_skip;
        for (int i = 0; i < 6; i++) begin
            vs_pulse();
            if (m_in_frame) strobes(FP);
            tick(3);
        end
        check("t2_frames_sent", int'(frames_sent), 3);
        check("t2_frames_skipped", int'(frames_skipped), skip0 + 4);

        // cts gating; cts drop mid-frame is ignored.
        decim = 4'd1;
        skip0 = m_skip;
        cts = 1'b0;
        tick(3);
        vs_pulse();
        cts = 1'b1;
        tick(3);
        vs_pulse();
        strobes(5);
        cts = 1'b0;
        strobes(FP - 5);
        tick(3);
        check("t3_frames_sent", int'(frames_sent), 4);
        check("t3_frames_skipped", int'(frames_skipped), skip0 + 1);
        cts = 1'b1;
        tick(3);

        // Short frame ended by the next boundary after 10 pixels.
        vs_pulse();
        strobes(10);
        tick(2);
        vs_pulse();
        tick(3);
        check("t4_pix_count", int'(pix_count), 10);
        check("t4_frames_sent", int'(frames_sent), 5);
        check("t4_state_idle", int'(state), 0);

        // Randomized decimation, cts and frame lengths.
        for (int it = 0; it < 12; it++) begin
            decim = 4'($urandom_range(0, 3));
            cts = ($urandom_range(0, 3) != 0);
            tick(3);
            vs_pulse();
            if (m_in_frame) begin
                if ($urandom_range(0, 1) == 1) begin
                    strobes(FP);
                end else begin
                    strobes($urandom_range(1, FP - 1));
                    tick(1);
                    vs_pulse();
                end
            end
            tick(3);
            check("rnd_frames_sent", int'(frames_sent), m_sent);
            check("rnd_frames_skipped", int'(frames_skipped), m_skip);
        end
        cts = 1'b1; decim = 4'd1;
        tick(3);

        // Watchdog: no strobes after frame start.
        model_boundary();
        v_sync = 1'b0;
        n = 0;
        while (state != 2'd1 && n < 20) begin
            tick(1);
            n++;
        end
        check("t5_enter_send", n, 4);
        v_sync = 1'b1;
        m_in_frame = 0;
        m_err = 1;
        n = 0;
        while (state == 2'd1 && n < 100) begin
            tick(1);
            n++;
        end
        check("t5_wd_cycles", n, TO);
        check("t5_state_err", int'(state), 3);
        check("t5_timeout_err", int'(timeout_err), 1);
        check("t5_send_frame_low", int'(send_frame), 0);
        skip0 = m_skip;
        vs_pulse();
        check("t5_err_ignores_vs", int'(state), 3);
        check("t5_err_skip_unchanged", int'(frames_skipped), skip0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        m_err = 0;
        check("t5_clr_state", int'(state), 0);
        check("t5_clr_flag", int'(timeout_err), 0);
        tick(3);

        // Enable abort mid-frame.
        sent0 = m_sent;
        vs_pulse();
        strobes(5);
        enable = 1'b0;
        m_in_frame = 0;
        tick(1);
        check("t6_abort_state", int'(state), 0);
        check("t6_abort_send_frame", int'(send_frame), 0);
        enable = 1'b1;
        tick(4);
        check("t6_abort_sent_unchanged", int'(frames_sent), sent0);

        // Asynchronous reset mid-frame.
        vs_pulse();
        strobes(4);
        #3;
        rst = 1'b1;
        #1;
        check("t6_rst_send_frame", int'(send_frame), 0);
        check("t6_rst_state", int'(state), 0);
        check("t6_rst_frames_sent", int'(frames_sent), 0);
        check("t6_rst_pix_count", int'(pix_count), 0);
        m_sent = 0; m_skip = 0; m_elig = 0; m_pix = 0; m_in_frame = 0; m_err = 0;
        tick(2);
        rst = 1'b0;
        starts0 = n_start;
        tick(10);
        check("t6_no_start_after_rst", n_start, starts0);
        vs_pulse();
        strobes(FP);
        tick(3);
        check("t6_frame_after_rst", int'(frames_sent), 1);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
